// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if
// Handshake and data bundle for stream_mux_rr. Directions in the signal
// suffixes (_i/_o) are as seen by the multiplexer. The slave modport is
// the multiplexer's view; the master modport is the producers' and
// consumer's view.
interface stream_mux_rr_if #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*SIZE-1:0] data_i;   // channel k at [k*SIZE +: SIZE]
    logic [CHANNELS-1:0]      valid_i;  // channel k offers a word
    logic [CHANNELS-1:0]      ready_o;  // channel k's word is taken this cycle
    logic [SIZE-1:0]          data_o;   // registered output word
    logic                     valid_o;  // data_o holds an untaken word
    logic                     ready_i;  // consumer takes data_o this cycle
    logic [SEL_W-1:0]         sel_o;    // source channel of data_o

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, sel_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, sel_o
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-input to 1-output stream multiplexer with an internal arbiter and a
// registered output stage. One word per cycle at full rate, one cycle of
// latency, no combinational path from data_i to any output.
//
// Build option:
//   STREAM_MUX_RR_EN defined   -> round-robin arbitration; a pointer
//                                 register remembers the last winner and
//                                 the search starts just above it.
//   STREAM_MUX_RR_EN undefined -> fixed priority, lowest requesting index
//                                 wins; no pointer register exists.
module stream_mux_rr #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,   // asynchronous, active-low
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Output register stage
    logic [SIZE-1:0]     r_data;
    logic                r_valid;
    logic [SEL_W-1:0]    r_sel;

    // Arbitration and handshake
    logic                w_load_en;     // output stage can take a word
    logic                w_any_req;     // at least one channel requests
    logic                w_in_xfer;     // an input transfer happens this cycle
    logic [CHANNELS-1:0] w_grant;       // one-hot (or zero) grant
    logic [SEL_W-1:0]    w_grant_idx;   // binary index of the granted channel
    logic [SIZE-1:0]     w_grant_data;  // word of the granted channel

    // The output stage is free when empty or being drained this cycle.
    assign w_load_en = !r_valid || bus.ready_i;

`ifdef STREAM_MUX_RR_EN
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] r_ptr;  // channel that won the last accepted transfer

    // Round-robin search: first requester at or after ptr+1, wrapping.
    always_comb begin : p_arb
        int ch;
        // NOTE: every variable gets a default before any branch, so no
        // path leaves it unassigned and no latch is inferred.
        ch          = 0;
        w_grant     = '0;
        w_grant_idx = '0;
        w_any_req   = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            ch = int'(r_ptr) + i;
            if (ch >= CHANNELS) begin
                ch = ch - CHANNELS;
            end
            if (!w_any_req && bus.valid_i[ch]) begin
                w_any_req   = 1'b1;
                w_grant[ch] = 1'b1;
                w_grant_idx = SEL_W'(ch);
            end
        end
    end

    // Pointer follows the winner of each accepted input transfer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr <= LAST_CH;  // channel 0 gets first priority after reset
        end else if (w_in_xfer) begin
            r_ptr <= w_grant_idx;
        end
    end
`else
    // Fixed priority: the lowest requesting index wins.
    always_comb begin : p_arb
        w_grant     = '0;
        w_grant_idx = '0;
        w_any_req   = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (!w_any_req && bus.valid_i[ch]) begin
                w_any_req   = 1'b1;
                w_grant[ch] = 1'b1;
                w_grant_idx = SEL_W'(ch);
            end
        end
    end
`endif

    // AND-OR select of the granted channel's word; the grant is one-hot,
    // so at most one term contributes.
    always_comb begin : p_data_sel
        w_grant_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_grant[c]) begin
                w_grant_data = w_grant_data | bus.data_i[c*SIZE +: SIZE];
            end
        end
    end

    // A grant only becomes a handshake when the output stage can load.
    // Reset forces ready_o low even though the empty stage would otherwise
    // report load_en=1.
    assign w_in_xfer   = rst_i && w_load_en && w_any_req;
    assign bus.ready_o = (rst_i && w_load_en) ? w_grant : '0;

    // Output stage: load on an input transfer, empty on a pure drain,
    // hold otherwise (including under backpressure).
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst_i) begin
            // NOTE: data and select are reset as well as valid, because
            // both are visible on ports and must read 0 during reset.
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_grant_data;
            r_sel   <= w_grant_idx;
        end else if (r_valid && bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.sel_o   = r_sel;

    // Run-time properties of the handshake.
    // At most one channel is ever granted.
    a_ready_onehot : assert property (
        @(posedge clk_i) disable iff (!rst_i) $onehot0(bus.ready_o)
    );

    // A full, stalled output stage grants nobody.
    a_no_grant_when_stalled : assert property (
        @(posedge clk_i) disable iff (!rst_i)
        (r_valid && !bus.ready_i) |-> (bus.ready_o == '0)
    );

    // A stalled word holds its value, source and valid flag.
    a_hold_under_backpressure : assert property (
        @(posedge clk_i) disable iff (!rst_i)
        (r_valid && !bus.ready_i) |=> (r_valid && $stable(r_data) && $stable(r_sel))
    );

    // Any granted channel must actually be requesting.
    a_grant_implies_request : assert property (
        @(posedge clk_i) disable iff (!rst_i)
        ((bus.ready_o & ~bus.valid_i) == '0)
    );
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Self-checking bench for stream_mux_rr (SIZE=8, CHANNELS=4): a vector
// table, hand-written multi-cycle sequences, and randomized traffic
// compared against a behavioural model. Works with STREAM_MUX_RR_EN
// defined or undefined.
module tb_stream_mux_rr;
    localparam int SIZE     = 8;
    localparam int CHANNELS = 4;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    stream_mux_rr_if #(.SIZE(SIZE), .CHANNELS(CHANNELS)) bus ();

    stream_mux_rr #(.SIZE(SIZE), .CHANNELS(CHANNELS)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
`ifdef STREAM_MUX_RR_EN
    int         m_ptr;
`endif

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
`ifdef STREAM_MUX_RR_EN
        m_ptr   = CHANNELS - 1;
`endif
    endtask

    // Winner = requester with the smallest "distance": round-robin measures
    // it from the slot after the last winner, fixed priority uses the index.
    function automatic int pick(input logic [3:0] req);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = CHANNELS;
        for (int c = 0; c < CHANNELS; c++) begin
            if (req[c]) begin
`ifdef STREAM_MUX_RR_EN
                d = (c - m_ptr - 1 + 2 * CHANNELS) % CHANNELS;
`else
                d = c;
`endif
                if (d < bestd) begin
                    bestd = d;
                    best  = c;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        if (m_valid && !bus.ready_i) return 4'b0000;
        g = pick(bus.valid_i);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Called right after a rising edge, while pre-edge inputs are still held.
    task automatic model_update();
        int g;
        if (model_ready() != 4'b0000) begin
            g       = pick(bus.valid_i);
            m_data  = bus.data_i[g*SIZE +: SIZE];
            m_sel   = g;
            m_valid = 1'b1;
`ifdef STREAM_MUX_RR_EN
            m_ptr   = g;
`endif
        end else if (m_valid && bus.ready_i) begin
            m_valid = 1'b0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ready(input string name, input logic [3:0] exp);
        check({name, ".ready_o"}, 32'(bus.ready_o), 32'(exp));
    endtask

    task automatic check_out(input string name, input logic ev, input logic [7:0] ed,
                             input logic [1:0] es);
        check({name, ".valid_o"}, 32'(bus.valid_o), 32'(ev));
        check({name, ".data_o"},  32'(bus.data_o),  32'(ed));
        check({name, ".sel_o"},   32'(bus.sel_o),   32'(es));
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic r);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        #1;
    endtask

    // One model-checked cycle, entered and left just after a falling edge.
    task automatic step(input string name, input logic [3:0] v, input logic [31:0] d,
                        input logic r);
        drive(v, d, r);
        check_ready(name, model_ready());
        @(posedge clk);
        model_update();
        #1;
        check_out(name, m_valid, m_data, 2'(m_sel));
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_ch;
        logic [3:0] exp_rdy;
        n_checks = 0;
        n_errors = 0;

        // Single-requester rows: identical expectations for both arbiters.
        vecs[0] = '{4'b0001, 32'h000000A5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0}; // first word after reset
        vecs[1] = '{4'b0100, 32'h00330000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0}; // backpressure 1
        vecs[2] = '{4'b0100, 32'h00330000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0}; // backpressure 2
        vecs[3] = '{4'b0100, 32'h00330000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0}; // backpressure 3
        vecs[4] = '{4'b0100, 32'h00330000, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2}; // release: ch2 taken
        vecs[5] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2}; // drain to empty
        vecs[6] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2}; // idle
        vecs[7] = '{4'b1000, 32'h77000000, 1'b0, 4'b1000, 1'b1, 8'h77, 2'd3}; // empty loads despite !ready_i
        vecs[8] = '{4'b0010, 32'h00001100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1}; // drain and fill together
        vecs[9] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1}; // drain

        // Reset held with random inputs: outputs and ready_o stay zero.
        rst_n       = 1'b0;
        bus.valid_i = '0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            bus.valid_i = 4'($urandom);
            bus.data_i  = $urandom;
            bus.ready_i = 1'($urandom);
            #3;
            check_ready("reset", 4'b0000);
            check_out("reset", 1'b0, 8'h00, 2'd0);
            @(posedge clk);
            #1;
            check_out("reset_edge", 1'b0, 8'h00, 2'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].rdy);
            check_ready($sformatf("vec%0d", i), vecs[i].exp_ready);
            @(posedge clk);
            model_update();
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_sel);
            @(negedge clk);
        end

        // Fairness: all four requesting at full rate from a fresh reset.
        rst_n = 1'b0;
        #1;
        check_out("pulse_reset", 1'b0, 8'h00, 2'd0);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
`ifdef STREAM_MUX_RR_EN
            exp_ch = k % CHANNELS;
`else
            exp_ch = 0;
`endif
            drive(4'b1111, 32'h44332211, 1'b1);
            check_ready($sformatf("fair%0d", k), 4'(1 << exp_ch));
            @(posedge clk);
            model_update();
            #1;
            check_out($sformatf("fair%0d", k), 1'b1, 8'((exp_ch + 1) * 8'h11), 2'(exp_ch));
            @(negedge clk);
        end

        // Wrap and skip: win on ch2, then only ch1 requests (wraps past 3, 0),
        // then everyone requests and the search resumes at ch2.
        drive(4'b0100, 32'h00550000, 1'b1);
        check_ready("wrap_a", 4'b0100);
        @(posedge clk);
        model_update();
        #1;
        check_out("wrap_a", 1'b1, 8'h55, 2'd2);
        @(negedge clk);

        drive(4'b0010, 32'h00006600, 1'b1);
        check_ready("wrap_b", 4'b0010);
        @(posedge clk);
        model_update();
        #1;
        check_out("wrap_b", 1'b1, 8'h66, 2'd1);
        @(negedge clk);

`ifdef STREAM_MUX_RR_EN
        exp_ch = 2;
`else
        exp_ch = 0;
`endif
        exp_rdy = 4'(1 << exp_ch);
        drive(4'b1111, 32'h44332211, 1'b1);
        check_ready("wrap_c", exp_rdy);
        @(posedge clk);
        model_update();
        #1;
        check_out("wrap_c", 1'b1, 8'((exp_ch + 1) * 8'h11), 2'(exp_ch));
        @(negedge clk);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step("rand", 4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            step("stream", 4'b1111, $urandom, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 2'd0);
        check_ready("async_rst", 4'b0000);
        model_reset();
        bus.valid_i = 4'b1001;
        bus.data_i  = 32'hBB0000CC;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_out("async_hold", 1'b0, 8'h00, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ready("after_rst", 4'b0001);
        @(posedge clk);
        model_update();
        #1;
        check_out("after_rst", 1'b1, 8'hCC, 2'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input to 1-output stream multiplexer with a registered output and a valid/ready handshake on every port. Selection comes from an internal arbiter rather than an external select line. The block sits between several producers (e.g. pipeline-stage result sources) and a single consumer. It delivers one transfer per cycle at full throughput, with one cycle of latency.

## Interface
Parameters:
- SIZE, default 32: data width per channel in bits (≥1).
- CHANNELS, default 4: number of input channels (≥1).
- SEL_W (localparam) = max(1, clog2(CHANNELS)): width of the grant index.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- data_i  input  CHANNELS*SIZE  channel k occupies bits [k*SIZE +: SIZE].
- valid_i  input  CHANNELS  channel k offers data.
- ready_o  output  CHANNELS  channel k's data is taken this cycle.
- data_o  output  SIZE  registered output data.
- valid_o  output  1  data_o holds an untaken word.
- ready_i  input  1  consumer accepts data_o this cycle.
- sel_o  output  SEL_W  index of the channel whose word is in data_o.

## Operation
- Input transfer on channel k: valid_i[k] && ready_o[k]. Output transfer: valid_o && ready_i.
- load_en = !valid_o || ready_i. The output register accepts a new word when it is empty or being drained.
- Arbiter request vector = valid_i. Grant is one-hot, combinational, and at most one bit is set.
- ready_o[k] = load_en && grant[k]. ready_o is all-zero when load_en=0 or no request is present.
- On a clock edge with an input transfer on channel g:
  - data_o ← data_i[g].
  - sel_o ← g.
  - valid_o ← 1.
  - ptr ← g.
- On an edge with an output transfer and no input transfer: valid_o ← 0. data_o and sel_o hold their old values.
- With valid_o=1 and ready_i=0, data_o, sel_o and valid_o hold. No channel is granted.
- Round-robin arbitration: search from channel (ptr+1) mod CHANNELS upward, wrapping. The first requesting channel wins. ptr updates only on an accepted input transfer.
- CHANNELS=1: grant = valid_i[0] and sel_o is constantly 0.
- Producers keep valid_i and data_i stable until accepted. The block does not require this; a dropped request is simply not granted.

## Timing
- Reset (rst_i=0, takes effect immediately, no clock needed):
  - valid_o=0, data_o=0, sel_o=0.
  - ptr=CHANNELS-1, so channel 0 has first priority.
  - ready_o=0 while in reset.
- Latency: an input accepted at edge n appears on data_o/valid_o after edge n.
- Throughput: one word per cycle when ready_i is held at 1.
- ready_o depends combinationally on ready_i, valid_o, valid_i and ptr. There is no combinational path from data_i to any output.
- Simultaneous drain and fill in the same cycle: the new word replaces the old one, valid_o stays 1 with no bubble.
- Reset asserted mid-transfer: the pending output word is discarded and no handshake completes on that edge. After rst_i deasserts, the first edge behaves as post-reset.

## Configuration
- STREAM_MUX_RR_EN:
  - Defined: round-robin arbitration with the ptr register, as described above.
  - Undefined: fixed priority, lowest requesting index wins. The ptr register is not instantiated. All other behaviour and timing are unchanged.

## Test plan
- Reset: hold rst_i=0 with random inputs -> valid_o=0, data_o=0, sel_o=0, ready_o=4'b0000. Deassert rst_i, drive valid_i=4'b0001, data_i[0]=8'hA5 -> after one edge data_o=8'hA5, sel_o=0, valid_o=1.
- Round-robin fairness: SIZE=8, CHANNELS=4, valid_i=4'b1111 held, ready_i=1 -> sel_o sequence 0,1,2,3,0,… with one word per cycle and no gaps. Without the macro -> sel_o stays 0.
- Wrap and skip: ptr=2, valid_i=4'b0010 -> channel 1 is granted (wrapping past 3 and 0), then the next grant search starts at channel 2.
- Backpressure: valid_o=1, ready_i=0 for 3 cycles with valid_i=4'b0100 -> ready_o=0 and data_o/sel_o stable. Raise ready_i -> ready_o[2]=1 that cycle and the new word appears on the next edge.
- Drain to empty: valid_o=1, ready_i=1, valid_i=0 -> valid_o=0 after the edge and data_o holds its previous value.
- Async reset mid-stream: assert rst_i between edges during a full-rate transfer -> valid_o=0 immediately. On release, channel 0 has priority: valid_i=4'b1001 grants channel 0.
